// File: rtl/spi_slave.sv
// SPI mode-0 target endpoint: oversampled SCK/CSn/MOSI, MSB-first fixed-width words,
// one-entry transmit holding register and a single-cycle receive strobe.
module spi_slave #(
    parameter int unsigned K_WIDTH = 16,
    parameter int unsigned K_SYNC  = 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_sck,
    input  logic               i_csn,
    input  logic               i_mosi,
    output logic               o_miso,
    output logic               o_miso_oe,
    input  logic [K_WIDTH-1:0] i_data,
    input  logic               i_load,
    output logic               o_tx_ready,
    output logic [K_WIDTH-1:0] o_data,
    output logic               o_valid,
    output logic               o_underrun,
    output logic               o_busy
);

    localparam int unsigned CNT_W = (K_WIDTH > 2) ? $clog2(K_WIDTH) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchronizer chains; CSn idles high so its chain resets to 1
    logic [K_SYNC-1:0] sck_sync;
    logic [K_SYNC-1:0] csn_sync;
    logic [K_SYNC-1:0] mosi_sync;
    logic              sck_prev;
    logic              csn_prev;

    logic              sck_s;
    logic              csn_s;
    logic              mosi_s;

    logic              sck_rise_c;
    logic              sck_fall_c;
    logic              csn_rise_c;
    logic              csn_fall_c;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [K_WIDTH-1:0] rx_shift;
    logic [K_WIDTH-1:0] tx_shift;
    logic [K_WIDTH-1:0] holding;
    logic              first_pending;

    logic              load_acc_c;
    logic              word_start_c;
    logic              last_bit_c;
    logic [K_WIDTH-1:0] start_word_c;
    logic              start_underrun_c;

    // Input synchronizers and previous-value flops for edge detection
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            csn_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[K_SYNC-2:0], i_sck};
            csn_sync  <= {csn_sync[K_SYNC-2:0], i_csn};
            mosi_sync <= {mosi_sync[K_SYNC-2:0], i_mosi};
            sck_prev  <= sck_sync[K_SYNC-1];
            csn_prev  <= csn_sync[K_SYNC-1];
        end
    end

    assign sck_s  = sck_sync[K_SYNC-1];
    assign csn_s  = csn_sync[K_SYNC-1];
    assign mosi_s = mosi_sync[K_SYNC-1];

    assign sck_rise_c = sck_s & ~sck_prev;
    assign sck_fall_c = ~sck_s & sck_prev;
    assign csn_rise_c = csn_s & ~csn_prev;
    assign csn_fall_c = ~csn_s & csn_prev;

    // Word-start selection: same-cycle load bypasses holding, else holding, else zero (underrun)
    always_comb begin
        load_acc_c       = i_load & o_tx_ready;
        last_bit_c       = (bit_cnt == CNT_W'(K_WIDTH - 1));
        word_start_c     = 1'b0;
        start_word_c     = '0;
        start_underrun_c = 1'b0;

        if (state == ST_IDLE) begin
            word_start_c = csn_fall_c;
        end else begin
            word_start_c = ~csn_rise_c & sck_fall_c & (bit_cnt == '0) & ~first_pending;
        end

        if (load_acc_c) begin
            start_word_c = i_data;
        end else if (!o_tx_ready) begin
            start_word_c = holding;
        end else begin
            start_word_c     = '0;
            start_underrun_c = 1'b1;
        end
    end

    // Transfer FSM, shift registers and holding-register handshake
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            holding       <= '0;
            first_pending <= 1'b0;
            o_tx_ready    <= 1'b1;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_underrun    <= 1'b0;
            o_miso_oe     <= 1'b0;
        end else begin
            o_valid    <= 1'b0;
            o_underrun <= 1'b0;
            o_miso_oe  <= ~csn_s;

            if (load_acc_c && !word_start_c) begin
                holding    <= i_data;
                o_tx_ready <= 1'b0;
            end

            if (word_start_c) begin
                tx_shift   <= start_word_c;
                o_underrun <= start_underrun_c;
                if (!load_acc_c && !o_tx_ready) begin
                    o_tx_ready <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (csn_fall_c) begin
                        state         <= ST_SHIFT;
                        bit_cnt       <= '0;
                        rx_shift      <= '0;
                        first_pending <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (csn_rise_c) begin
                        state         <= ST_IDLE;
                        bit_cnt       <= '0;
                        first_pending <= 1'b0;
                    end else if (sck_rise_c) begin
                        rx_shift      <= {rx_shift[K_WIDTH-2:0], mosi_s};
                        first_pending <= 1'b0;
                        if (last_bit_c) begin
                            o_data  <= {rx_shift[K_WIDTH-2:0], mosi_s};
                            o_valid <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sck_fall_c) begin
                        if (bit_cnt != '0) begin
                            tx_shift <= {tx_shift[K_WIDTH-2:0], 1'b0};
                        end else if (first_pending) begin
                            first_pending <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE);
    assign o_miso = o_miso_oe & tx_shift[K_WIDTH-1];

endmodule
